// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared owner enum, defaults and requester indices for the CHIP-8 RAM path
package chip8_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_GPU  = 2'd3
    } owner_t;

    localparam int          ADDR_W_DEF   = 12;
    localparam logic [11:0] PROT_END_DEF = 12'h200;
    localparam int          MAX_WAIT_DEF = 8;

    // Requester slots, shared with the loader, cpu and gpu blocks
    localparam int NUM_REQ = 3;
    localparam int REQ_LD  = 0;
    localparam int REQ_CPU = 1;
    localparam int REQ_GPU = 2;

    // Map a one-hot grant vector onto the owner that would hold the port
    function automatic owner_t owner_of(input logic [NUM_REQ-1:0] onehot);
        owner_t o;
        o = OWN_NONE;
        if (onehot[REQ_LD])       o = OWN_LD;
        else if (onehot[REQ_CPU]) o = OWN_CPU;
        else if (onehot[REQ_GPU]) o = OWN_GPU;
        return o;
    endfunction

endpackage

// File: rtl/chip8_prio_pick.sv
// rtl/chip8_prio_pick.sv - three-way fixed priority select with aged cpu/gpu swap
module chip8_prio_pick
    import chip8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               aged,
    output logic [NUM_REQ-1:0] gnt
);

    // Loader always wins; aging only swaps the cpu/gpu order beneath it
    always_comb begin
        gnt = '0;
        if (req[REQ_LD]) begin
            gnt[REQ_LD] = 1'b1;
        end else if (aged) begin
            if (req[REQ_GPU])      gnt[REQ_GPU] = 1'b1;
            else if (req[REQ_CPU]) gnt[REQ_CPU] = 1'b1;
        end else begin
            if (req[REQ_CPU])      gnt[REQ_CPU] = 1'b1;
            else if (req[REQ_GPU]) gnt[REQ_GPU] = 1'b1;
        end
    end

endmodule

// File: rtl/chip8_ram_arbiter.sv
// rtl/chip8_ram_arbiter.sv - single-port CHIP-8 RAM arbiter with burst lock, gpu aging and write protection
module chip8_ram_arbiter
    import chip8_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PROT_END = ADDR_W'(PROT_END_DEF),
    parameter int                MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ld_req,
    input  logic              ld_lock,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [7:0]        ld_rdata,

    input  logic              cpu_req,
    input  logic              cpu_lock,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,

    input  logic              gpu_req,
    input  logic              gpu_lock,
    input  logic              gpu_we,
    input  logic [ADDR_W-1:0] gpu_addr,
    input  logic [7:0]        gpu_wdata,
    output logic              gpu_gnt,
    output logic              gpu_rvalid,
    output logic [7:0]        gpu_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,

    output logic              prot_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    owner_t               owner, owner_nxt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [NUM_REQ-1:0]   req_v, lock_v, pick_gnt, gnt, rd_tag;
    logic                 aged;
    logic                 cpu_prot;
    logic                 prot_q;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [7:0]           sel_wdata;

    // The loader is write-only, so its we strobe carries no information
    logic unused_ld_we;
    assign unused_ld_we = ld_we;

    assign req_v  = {gpu_req, cpu_req, ld_req};
    assign lock_v = {gpu_lock, cpu_lock, ld_lock};
    assign aged   = (wait_cnt == WAIT_W'(MAX_WAIT));

    chip8_prio_pick u_pick (
        .req  (req_v),
        .aged (aged),
        .gnt  (pick_gnt)
    );

    // Owner register: reset drops any held burst lock
    always_ff @(posedge clk) begin
        if (rst) owner <= OWN_NONE;
        else     owner <= owner_nxt;
    end

    // Grant and next owner: an owner excludes everyone else, including its own final unlock cycle
    always_comb begin
        gnt       = '0;
        owner_nxt = owner;
        if (!rst) begin
            unique case (owner)
                OWN_NONE: begin
                    gnt = pick_gnt;
                    if ((gnt & lock_v) != '0) owner_nxt = owner_of(gnt);
                end
                OWN_LD: begin
                    gnt[REQ_LD] = ld_req;
                    if (!ld_lock) owner_nxt = OWN_NONE;
                end
                OWN_CPU: begin
                    gnt[REQ_CPU] = cpu_req;
                    if (!cpu_lock) owner_nxt = OWN_NONE;
                end
                OWN_GPU: begin
                    gnt[REQ_GPU] = gpu_req;
                    if (!gpu_lock) owner_nxt = OWN_NONE;
                end
                default: owner_nxt = OWN_NONE;
            endcase
        end
    end

    // RAM-side mux from the single granted requester
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[REQ_LD]) begin
            sel_we    = 1'b1;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end else if (gnt[REQ_CPU]) begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end else if (gnt[REQ_GPU]) begin
            sel_we    = gpu_we;
            sel_addr  = gpu_addr;
            sel_wdata = gpu_wdata;
        end
    end

    // A blocked cpu write is still granted so the cpu can move on, but never reaches the RAM
    assign cpu_prot  = gnt[REQ_CPU] & cpu_we & (cpu_addr < PROT_END);
    assign ram_en    = (|gnt) & ~cpu_prot;
    assign ram_we    = sel_we & ~cpu_prot;
    assign ram_addr  = sel_addr;
    assign ram_wdata = sel_wdata;

    assign ld_gnt  = gnt[REQ_LD];
    assign cpu_gnt = gnt[REQ_CPU];
    assign gpu_gnt = gnt[REQ_GPU];

    // GPU aging: count cpu wins over a waiting gpu, saturating; ld activity leaves it untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!gpu_req || gnt[REQ_GPU]) begin
            wait_cnt <= '0;
        end else if (gnt[REQ_CPU] && !aged) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Read tag and protection flag, both reported the cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_tag <= '0;
            prot_q <= 1'b0;
        end else begin
            rd_tag <= gnt & ~{gpu_we, cpu_we, 1'b1};
            prot_q <= cpu_prot;
        end
    end

    // Reset also masks a read that was already in flight
    assign ld_rvalid  = rd_tag[REQ_LD]  & ~rst;
    assign cpu_rvalid = rd_tag[REQ_CPU] & ~rst;
    assign gpu_rvalid = rd_tag[REQ_GPU] & ~rst;
    assign prot_err   = prot_q & ~rst;

    assign ld_rdata  = ram_rdata;
    assign cpu_rdata = ram_rdata;
    assign gpu_rdata = ram_rdata;

endmodule

// File: doc/chip8_ram_arbiter.md
# chip8_ram_arbiter

- Single-port arbiter for the 4 KiB CHIP-8 RAM, shared by three requesters:
  - ROM/font loader (writes only)
  - CPU: fetch, Fx33/Fx55/Fx65
  - GPU: Dxyn sprite-row fetch
- Sits between those blocks and the synchronous RAM in the top-level module.
- Provides fixed priority, burst locking for multi-byte sequences, anti-starvation aging for the GPU, and write protection of the font/interpreter region.

## Interface

Parameters:
- ADDR_W, 12, RAM address width (4096 bytes).
- PROT_END, 12'h200, first writable address for non-loader requesters; writes below it are blocked.
- MAX_WAIT, 8, cycles a pending GPU request may lose to the CPU before it is promoted.

Ports (k ∈ {ld, cpu, gpu}):
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- k_req  in  1  access request; held until granted.
- k_lock  in  1  keep ownership after this grant. Tie 0 for ld.
- k_we  in  1  write enable. Tie 0 for gpu; ld requests are always writes.
- k_addr  in  ADDR_W  byte address.
- k_wdata  in  8  write data.
- k_gnt  out  1  access accepted this cycle (combinational).
- k_rvalid  out  1  read data valid; registered, one cycle after a read grant.
- k_rdata  out  8  read data, valid when k_rvalid.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, one cycle after ram_en with !ram_we.
- prot_err  out  1  one-cycle pulse: a write to a protected address was blocked.

## Operation

Owner state: NONE, LD, CPU, GPU.

- **NONE:** grant the highest-priority requester.
  - Normal order: ld > cpu > gpu.
  - Aged order: ld > gpu > cpu, used when wait_cnt == MAX_WAIT.
- **Lock acquire:** if the winner has k_lock = 1 in its grant cycle, owner ← winner.
- **Owned:**
  - Only the owner may be granted.
  - Other requesters wait, including ld.
  - The owner may idle (req = 0) while still holding lock.
  - Owner → NONE in the first cycle its lock = 0. If that cycle also has owner req = 1, the owner gets that one final grant. Arbitration in that same cycle still excludes the others.
- **Grant cycle:**
  - ram_en = 1.
  - ram_addr, ram_wdata and ram_we are muxed from the granted requester.
  - ram_we = k_we, or 1 for ld.
- **Protection:**
  - Applies to cpu writes with addr < PROT_END.
  - The write is still granted, but ram_we is forced to 0 and ram_en to 0.
  - prot_err = 1 the following cycle.
  - ld is never protected.
- **Read return:**
  - A registered tag records the granted reader.
  - Next cycle: k_rvalid = 1 for that requester only, and k_rdata = ram_rdata.
  - All k_rdata outputs may share the ram_rdata wires; only rvalid is per-requester.
- **Aging (wait_cnt, saturating at MAX_WAIT):**
  - Increments when gpu_req = 1 and gpu is not granted because cpu won.
  - Clears on any gpu grant or when gpu_req = 0.
  - Does not count while ld holds or wins the port.
- No grant is issued when no req is asserted; ram_en = 0.

## Timing

- Grant latency is zero cycles (combinational from req/owner/wait_cnt). Read data arrives one cycle after the grant.
- Back-to-back grants, including to different requesters, are allowed every cycle. Throughput is one access per cycle.
- Reset values:
  - owner = NONE, wait_cnt = 0.
  - All rvalid = 0, prot_err = 0.
  - All gnt and ram_en are 0 while rst = 1.
- Reset mid-burst: the lock is dropped and an in-flight rvalid is suppressed on the next cycle. The requester must re-request.
- A requester must not change addr/we/wdata while req = 1 and gnt = 0.
- Lock asserted without req in NONE state has no effect.
- Address wrap: the address is used as-is (ADDR_W bits). No increment is done in this block.

## Structure

- chip8_pkg holds:
  - the owner enum (OWN_NONE, OWN_LD, OWN_CPU, OWN_GPU)
  - ADDR_W and PROT_END defaults
  - the requester index constants shared with cpu, gpu and loader
- One sub-module, chip8_prio_pick: combinational three-way priority select with an aged-swap input. It outputs a one-hot grant and is reused by the top level for a future VRAM arbiter.
- Owner register, wait counter, read tag and prot_err flop stay in chip8_ram_arbiter.

## Test plan

- **All three request together:** ld, cpu and gpu req at addr 0x000/0x200/0x300 in the same cycle → ld_gnt only. Next cycle cpu_gnt. Then gpu_gnt. gpu_rvalid one cycle after its grant with RAM[0x300].
- **GPU lock blocks CPU:** gpu lock burst of 5 reads 0x050–0x054 with cpu_req held → cpu_gnt = 0 throughout. cpu_gnt in the cycle after gpu_lock falls. 5 gpu_rvalid pulses in order.
- **Protected CPU write:** cpu writes 0xAB to 0x100 → cpu_gnt = 1, ram_en = 0, prot_err pulses next cycle, RAM[0x100] unchanged. Same write to 0x200 → RAM[0x200] = 0xAB, prot_err = 0.
- **Aging:** cpu_req held continuously, gpu_req held → gpu granted on the 9th cycle (MAX_WAIT = 8 losses). wait_cnt back to 0 afterwards.
- **Reset mid-burst:** rst asserted during a cpu lock burst, one cycle after a read grant → cpu_rvalid stays 0, owner = NONE. After rst falls, gpu_req is granted immediately.
- **Final grant on unlock:** owner cpu drops lock while issuing req → exactly one final cpu_gnt that cycle. A pending ld is granted the following cycle.
